debug_monitor: RTL

//  Parametrised on-board debug monitor: NUM_DIGITS 7-seg digits, NUM_REGS bus-writable debug regs, probe trigger/snapshot.

---
 rtl/debug_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/debug_monitor.sv
// On-board debug monitor: 7-seg nibble viewer, bus-writable debug registers,
// and a masked probe trigger with snapshot capture and a saturating hit counter.
module debug_monitor #(
  parameter int NUM_DIGITS = 2,
  parameter int NUM_REGS   = 4,
  parameter int PROBE_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              MCmd,
  input  logic [7:0]              MAddr,
  input  logic [7:0]              MData,
  output logic                    SCmdAccept,
  output logic [7:0]              SData,
  output logic [1:0]              SResp,
  input  logic [PROBE_W-1:0]      probe,
  input  logic [NUM_DIGITS-1:0]   pushed_up,
  input  logic [NUM_DIGITS-1:0]   pushed_dn,
  input  logic                    pushing,
  output logic [8*NUM_DIGITS-1:0] seg
);

  logic [7:0] regs   [NUM_REGS];
  logic [3:0] sel    [NUM_DIGITS];
  logic [3:0] shown  [NUM_DIGITS];
  logic [3:0] src    [NUM_DIGITS];
  logic [7:0] trig_val, trig_mask, snapshot, hit_cnt;
  logic       armed, freeze, triggered;
  logic [7:0] probe8, rdata;
  logic [6:0] addr;
  logic       wr, rd, ctrl_wr, clr, match;

  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    id_byte = 8'h44;
      3'd1:    id_byte = 8'h42;
      3'd2:    id_byte = 8'h47;
      3'd3:    id_byte = 8'h4D;
      3'd4:    id_byte = 8'h4F;
      3'd5:    id_byte = 8'h4E;
      3'd6:    id_byte = 8'h30;
      default: id_byte = 8'h32;
    endcase
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0; 4'h1: seg7 = 8'hF9; 4'h2: seg7 = 8'hA4; 4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99; 4'h5: seg7 = 8'h92; 4'h6: seg7 = 8'h82; 4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80; 4'h9: seg7 = 8'h90; 4'hA: seg7 = 8'h88; 4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6; 4'hD: seg7 = 8'hA1; 4'hE: seg7 = 8'h86; default: seg7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    probe8 = '0;
    probe8[PROBE_W-1:0] = probe;
  end

  assign SCmdAccept = 1'b1;
  assign addr    = MAddr[6:0];
  assign wr      = (MCmd == 3'b001);
  assign rd      = (MCmd == 3'b010);
  assign ctrl_wr = wr && (addr == 7'h30);
  assign clr     = ctrl_wr && MData[2];
  // Trigger sees the register state before any same-cycle bus write lands.
  assign match   = armed && (((probe8 ^ trig_val) & trig_mask) == 8'h00);

  always_comb begin
    rdata = '0;
    case (addr[6:4])
      3'h0: if (!addr[3]) rdata = id_byte(addr[2:0]);
      3'h1: for (int unsigned i = 0; i < NUM_REGS; i++)
              if (addr[3:0] == 4'(i)) rdata = regs[i];
      3'h2: for (int unsigned d = 0; d < NUM_DIGITS; d++)
              if (addr[3:0] == 4'(d)) rdata = {4'h0, sel[d]};
      3'h3: case (addr[3:0])
              4'h0: rdata = {5'b0, triggered, freeze, armed};
              4'h1: rdata = trig_val;
              4'h2: rdata = trig_mask;
              4'h3: rdata = snapshot;
              4'h4: rdata = hit_cnt;
              default: rdata = '0;
            endcase
      default: rdata = '0;
    endcase
  end

  // Sources 8..15 map to debug reg (s[2:1]), nibble half s[0].
  always_comb begin
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      src[d] = '0;
      if (sel[d][3]) begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
          if (32'(sel[d][2:1]) == i)
            src[d] = sel[d][0] ? regs[i][7:4] : regs[i][3:0];
      end else begin
        case (sel[d][2:0])
          3'd0: src[d] = snapshot[3:0];
          3'd1: src[d] = snapshot[7:4];
          3'd2: src[d] = {triggered, freeze, armed, 1'b0};
          3'd3: src[d] = hit_cnt[3:0];
          3'd4: src[d] = hit_cnt[7:4];
          default: src[d] = '0;
        endcase
      end
    end
  end

  always_comb begin
    seg = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      seg[8*d +: 8] = seg7(pushing ? sel[d] : shown[d]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SData <= '0;
      SResp <= '0;
    end else begin
      SResp <= rd ? 2'b01 : 2'b00;
      if (rd) SData <= rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (wr && addr == 7'h10 + 7'(i)) regs[i] <= MData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        sel[d]   <= '0;
        shown[d] <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        if (wr && addr == 7'h20 + 7'(d)) sel[d] <= MData[3:0];
        else if (pushed_up[d])           sel[d] <= sel[d] + 4'd1;
        else if (pushed_dn[d])           sel[d] <= sel[d] - 4'd1;
        shown[d] <= src[d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_val  <= '0;
      trig_mask <= '0;
      armed     <= 1'b0;
      freeze    <= 1'b0;
      triggered <= 1'b0;
      snapshot  <= '0;
      hit_cnt   <= '0;
    end else begin
      if (wr && addr == 7'h31) trig_val  <= MData;
      if (wr && addr == 7'h32) trig_mask <= MData;
      if (ctrl_wr) begin
        armed  <= MData[0];
        freeze <= MData[1];
      end else if (match) begin
        armed  <= 1'b0;
      end
      if (clr)        triggered <= 1'b0;
      else if (match) triggered <= 1'b1;
      if (clr)                             hit_cnt <= '0;
      else if (match && hit_cnt != 8'hFF)  hit_cnt <= hit_cnt + 8'd1;
      if (match || (!freeze && !triggered)) snapshot <= probe8;
    end
  end

endmodule
